everloop_ws2812_tx: RTL and testbench

Downstream stage of the everloop RAM. Continuously scans the LED byte RAM through its read port (port B) and serializes each byte into the single-wire WS2812/SK6812 NRZ protocol on the physical everloop pin. A latch/reset gap is inserted between frames, and the RAM is rescanned from address 0 every frame, so Wishbone writes appear on the LEDs on the next frame.

---
 rtl/everloop_ws2812_tx.sv | 183 ++++++++++++++++++
 tb/tb_everloop_ws2812_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/everloop_ws2812_tx.sv
`default_nettype none
// ============================================================================
// Module      : everloop_ws2812_tx
// Description : Scans the everloop LED byte RAM on every frame and serializes
//               each byte MSB first onto the single-wire WS2812/SK6812 NRZ
//               line. Each frame is preceded by a low latch gap. The next byte
//               is prefetched during bit 0 of the current byte, so bytes follow
//               each other with no idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module everloop_ws2812_tx #(
    parameter int NUM_LEDS      = 35,
    parameter int BYTES_PER_LED = 4,
    parameter int ADR_WIDTH     = 11,
    parameter int T_BIT         = 63,
    parameter int T0H           = 18,
    parameter int T1H           = 35,
    parameter int RESET_CYCLES  = 3000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic [ADR_WIDTH-1:0] address,
    input  logic [7:0]           data_RGB,
    output logic                 everloop_d,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int FRAME_BYTES = NUM_LEDS * BYTES_PER_LED;
    localparam int CW          = $clog2(T_BIT);
    localparam int LW          = $clog2(RESET_CYCLES + 1);

    localparam logic [CW-1:0]        C_ZERO    = CW'(0);
    localparam logic [CW-1:0]        C_ONE     = CW'(1);
    localparam logic [CW-1:0]        C_CAPTURE = CW'(2);
    localparam logic [CW-1:0]        C_LAST    = CW'(T_BIT - 1);
    localparam logic [CW-1:0]        T0H_C     = CW'(T0H);
    localparam logic [CW-1:0]        T1H_C     = CW'(T1H);
    localparam logic [LW-1:0]        LAT_LAST  = LW'(RESET_CYCLES - 1);
    localparam logic [LW-1:0]        LAT_ONE   = LW'(1);
    localparam logic [ADR_WIDTH-1:0] LAST_BYTE = ADR_WIDTH'(FRAME_BYTES - 1);
    localparam logic [ADR_WIDTH-1:0] ADR_ONE   = ADR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        FETCH = 3'd2,
        LOAD  = 3'd3,
        BITS  = 3'd4
    } state_t;

    state_t                 state;
    logic [LW-1:0]          lat_cnt;
    logic [CW-1:0]          cyc;
    logic [2:0]             bit_idx;
    logic [ADR_WIDTH-1:0]   byte_idx;
    logic [7:0]             sh;
    logic [7:0]             nxt;

    logic                   last_cyc;
    logic                   last_bit;
    logic                   last_byte;
    logic                   first_bit;
    logic [CW-1:0]          cyc_inc;
    logic [CW-1:0]          high_len;

    // Bit-cell position decode and the high-time of the bit now on the line
    always_comb begin
        last_cyc  = (cyc == C_LAST);
        last_bit  = (bit_idx == 3'd7);
        last_byte = (byte_idx == LAST_BYTE);
        first_bit = (bit_idx == 3'd0);
        cyc_inc   = cyc + C_ONE;
        high_len  = sh[7] ? T1H_C : T0H_C;
    end

    // Frame sequencer; everloop_d and frame_done are computed one cycle ahead
    // so that both leave the block straight from flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            cyc        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            sh         <= '0;
            nxt        <= '0;
            address    <= '0;
            everloop_d <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    everloop_d <= 1'b0;
                    address    <= '0;
                    if (enable) begin
                        state   <= LATCH;
                        busy    <= 1'b1;
                        lat_cnt <= '0;
                    end
                end

                LATCH: begin
                    everloop_d <= 1'b0;
                    if (lat_cnt == LAT_LAST) begin
                        state <= FETCH;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_ONE;
                    end
                end

                // Address 0 is already on the RAM; this cycle covers its latency
                FETCH: begin
                    state <= LOAD;
                end

                LOAD: begin
                    sh         <= data_RGB;
                    bit_idx    <= '0;
                    byte_idx   <= '0;
                    cyc        <= '0;
                    everloop_d <= 1'b1;
                    state      <= BITS;
                end

                BITS: begin
                    // Prefetch the following byte while bit 0 is on the line
                    if (first_bit && !last_byte && (cyc == C_ZERO)) begin
                        address <= byte_idx + ADR_ONE;
                    end
                    if (first_bit && !last_byte && (cyc == C_CAPTURE)) begin
                        nxt <= data_RGB;
                    end

                    if (last_cyc) begin
                        cyc <= '0;
                        if (last_bit && last_byte) begin
                            // Frame complete: rescan from address 0
                            everloop_d <= 1'b0;
                            address    <= '0;
                            byte_idx   <= '0;
                            bit_idx    <= '0;
                            if (enable) begin
                                state   <= LATCH;
                                lat_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (last_bit) begin
                            sh         <= nxt;
                            byte_idx   <= byte_idx + ADR_ONE;
                            bit_idx    <= '0;
                            everloop_d <= 1'b1;
                        end else begin
                            sh         <= {sh[6:0], 1'b0};
                            bit_idx    <= bit_idx + 3'd1;
                            everloop_d <= 1'b1;
                        end
                    end else begin
                        cyc        <= cyc_inc;
                        everloop_d <= (cyc_inc < high_len);
                        if (last_bit && last_byte && (cyc_inc == C_LAST)) begin
                            frame_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    everloop_d <= 1'b0;
                    address    <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_everloop_ws2812_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_everloop_ws2812_tx
// Description : Self-checking bench for everloop_ws2812_tx. The serial line is
//               recorded every cycle and decoded back into bytes from the
//               measured high/low run lengths; frame timing, address order and
//               idle behaviour are derived from the protocol arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_everloop_ws2812_tx;

    localparam int NL        = 2;
    localparam int BPL       = 4;
    localparam int AW        = 11;
    localparam int TB        = 6;
    localparam int T0        = 2;
    localparam int T1        = 4;
    localparam int RC        = 10;
    localparam int NB        = NL * BPL;
    localparam int GAP       = RC + 2;
    localparam int BYTE_CYC  = 8 * TB;
    localparam int FRAME_CYC = GAP + BYTE_CYC * NB;
    localparam int MAXT      = 20000;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [AW-1:0] address;
    logic [7:0]    data_RGB;
    logic          everloop_d;
    logic          busy;
    logic          frame_done;

    logic [7:0]    ram       [NB];
    logic [7:0]    exp_frame [NB];
    logic [7:0]    pat       [NB];

    logic          tr_d    [MAXT];
    logic          tr_busy [MAXT];
    logic          tr_fd   [MAXT];
    logic [AW-1:0] tr_addr [MAXT];

    int cyc;
    int n_checks;
    int n_pass;
    int frame_no;

    everloop_ws2812_tx #(
        .NUM_LEDS      (NL),
        .BYTES_PER_LED (BPL),
        .ADR_WIDTH     (AW),
        .T_BIT         (TB),
        .T0H           (T0),
        .T1H           (T1),
        .RESET_CYCLES  (RC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .address    (address),
        .data_RGB   (data_RGB),
        .everloop_d (everloop_d),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM, one cycle latency
    always @(posedge clk) data_RGB <= ram[address[2:0]];

    // Cycle index
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle trace of the outputs, sampled mid-cycle
    always @(negedge clk) begin
        if (cyc < MAXT) begin
            tr_d[cyc]    <= everloop_d;
            tr_busy[cyc] <= busy;
            tr_fd[cyc]   <= frame_done;
            tr_addr[cyc] <= address;
        end
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic end_sim();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < NB; i++) begin
            ram[i]       = v;
            exp_frame[i] = v;
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_busy(input int budget, output int idx);
        idx = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy) begin
                idx = cyc;
                break;
            end
        end
        if (idx < 0) check("busy_timeout", 0, 1);
    endtask

    // Decode one recorded frame starting at its latch-gap entry cycle
    task automatic analyze_frame(input int start);
        int end_i, r, p, h, l, bad_per, bad_w, nfd, fd_at, nbusy0, steps, bad_addr;
        logic [AW-1:0] prev;
        logic [7:0] got [NB];
        end_i = start + FRAME_CYC - 1;
        if (end_i + 1 >= MAXT) begin
            check("trace_room", 0, 1);
            return;
        end
        r = -1;
        for (int t = start; t <= end_i; t++) if (tr_d[t] && r < 0) r = t;
        check($sformatf("f%0d_gap_low", frame_no), r - start, GAP);
        if (r < 0) r = end_i + 1;
        p = r;
        bad_per = 0;
        bad_w   = 0;
        for (int k = 0; k < 8 * NB; k++) begin
            h = 0;
            while (p <= end_i && tr_d[p]) begin h++; p++; end
            l = 0;
            while (p <= end_i && !tr_d[p]) begin l++; p++; end
            if (h + l != TB) bad_per++;
            if (h != T0 && h != T1) bad_w++;
            got[k / 8][7 - (k % 8)] = (2 * h > T0 + T1);
        end
        check($sformatf("f%0d_bit_period", frame_no), bad_per, 0);
        check($sformatf("f%0d_high_width", frame_no), bad_w, 0);
        for (int i = 0; i < NB; i++)
            check($sformatf("f%0d_byte%0d", frame_no, i), got[i], exp_frame[i]);
        nfd = 0;
        fd_at = -1;
        nbusy0 = 0;
        for (int t = start; t <= end_i; t++) begin
            if (tr_fd[t]) begin
                nfd++;
                if (fd_at < 0) fd_at = t;
            end
            if (!tr_busy[t]) nbusy0++;
        end
        check($sformatf("f%0d_done_at", frame_no), fd_at - start, FRAME_CYC - 1);
        check($sformatf("f%0d_done_count", frame_no), nfd, 1);
        check($sformatf("f%0d_busy_low", frame_no), nbusy0, 0);
        prev = tr_addr[start];
        steps = 0;
        bad_addr = (prev != 0) ? 1 : 0;
        for (int t = start + 1; t <= end_i; t++) begin
            if (tr_addr[t] != prev) begin
                steps++;
                prev = tr_addr[t];
                if (int'(prev) != steps) bad_addr++;
            end
        end
        check($sformatf("f%0d_addr_steps", frame_no), steps, NB - 1);
        check($sformatf("f%0d_addr_order", frame_no), bad_addr, 0);
        check($sformatf("f%0d_addr_ret", frame_no), tr_addr[end_i + 1], 0);
        frame_no++;
    endtask

    task automatic finish_frame(input int start, output int fd_idx);
        fd_idx = -1;
        for (int i = 0; i < FRAME_CYC + 50; i++) begin
            @(negedge clk);
            if (frame_done) begin
                fd_idx = cyc;
                break;
            end
        end
        if (fd_idx < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            @(negedge clk);
            analyze_frame(start);
        end
    endtask

    initial begin
        int start, fd, rel, cnt, j, k, tgt;
        logic [7:0] v;
        n_checks = 0;
        n_pass   = 0;
        frame_no = 0;
        pat[0] = 8'hA5; pat[1] = 8'h00; pat[2] = 8'hFF; pat[3] = 8'h01;
        pat[4] = 8'h80; pat[5] = 8'h7F; pat[6] = 8'h55; pat[7] = 8'hAA;
        for (int i = 0; i < NB; i++) begin
            ram[i]       = pat[i];
            exp_frame[i] = pat[i];
        end
        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_d", everloop_d, 0);
        check("rst_addr", address, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);

        // First frame after reset with the reference pattern
        enable = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        wait_busy(20, start);
        if (start < 0) end_sim();
        finish_frame(start, fd);
        if (fd < 0) end_sim();

        // Constant patterns, back to back
        for (int p = 0; p < 2; p++) begin
            start = fd + 1;
            fill(p == 0 ? 8'h00 : 8'hFF);
            finish_frame(start, fd);
            if (fd < 0) end_sim();
        end

        // Random frames, later ones with a write to a byte not yet prefetched
        for (int f = 0; f < 6; f++) begin
            start = fd + 1;
            for (int i = 0; i < NB; i++) begin
                ram[i]       = 8'($urandom);
                exp_frame[i] = ram[i];
            end
            if (f >= 2) begin
                j   = $urandom_range(0, NB - 3);
                k   = $urandom_range(j + 2, NB - 1);
                v   = 8'($urandom);
                tgt = start + GAP + j * BYTE_CYC + $urandom_range(0, BYTE_CYC - 1);
                wait_to(tgt);
                ram[k]       = v;
                exp_frame[k] = v;
            end
            finish_frame(start, fd);
            if (fd < 0) end_sim();
        end

        // Mid-frame write to byte 6 during byte 1, then enable dropped in byte 3
        start = fd + 1;
        fill(8'h00);
        wait_to(start + GAP + BYTE_CYC + 10);
        ram[6]       = 8'hFF;
        exp_frame[6] = 8'hFF;
        wait_to(start + GAP + 3 * BYTE_CYC + 20);
        enable = 1'b0;
        finish_frame(start, fd);
        if (fd < 0) end_sim();
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy || everloop_d || frame_done || address != 0) cnt++;
        end
        check("idle_quiet", cnt, 0);

        // Asynchronous reset during bit 5 of byte 2
        for (int i = 0; i < NB; i++) begin
            ram[i]       = 8'($urandom);
            exp_frame[i] = ram[i];
        end
        enable = 1'b1;
        wait_busy(10, start);
        if (start < 0) end_sim();
        wait_to(start + GAP + 2 * BYTE_CYC + 5 * TB);
        check("pre_rst_d", everloop_d, 1);
        check("pre_rst_addr", address, 3);
        #1 reset = 1'b0;
        #1;
        check("async_rst_d", everloop_d, 0);
        check("async_rst_addr", address, 0);
        check("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rel = cyc;
        wait_busy(10, start);
        if (start < 0) end_sim();
        cnt = 0;
        for (int t = rel; t < start; t++) if (tr_d[t]) cnt++;
        check("post_rst_low", cnt, 0);
        finish_frame(start, fd);
        end_sim();
    end

endmodule
`default_nettype wire
